// File: rtl/vmx_result_collector_pkg.sv
// rtl/vmx_result_collector_pkg.sv - widths, FSM states and requant helpers for the vmx result collector
package vmx_result_collector_pkg;

  localparam int SUM_BITLEN      = 32;
  localparam int ACC_BITLEN      = 40;
  localparam int OUT_BITLEN      = 16;
  localparam int CNT_BITLEN      = 16;
  localparam int LANE_SUM_BITLEN = SUM_BITLEN / 2;
  localparam int LANE_ACC_BITLEN = ACC_BITLEN / 2;
  localparam int LANE_OUT_BITLEN = OUT_BITLEN / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                  tlast;
    logic [OUT_BITLEN-1:0] tdata;
  } out_word_t;

  // Round-half-up, arithmetic shift and signed saturation, all at accumulator width.
  function automatic logic [OUT_BITLEN-1:0] requant_norm(input logic signed [ACC_BITLEN-1:0] x,
                                                         input logic [4:0] shift);
    logic signed [ACC_BITLEN-1:0] rnd;
    logic signed [ACC_BITLEN-1:0] r;
    rnd = (shift == 5'd0) ? '0 : (ACC_BITLEN'(1) << (shift - 5'd1));
    r   = (x + rnd) >>> shift;
    if (r[ACC_BITLEN-1:OUT_BITLEN-1] == '0 || r[ACC_BITLEN-1:OUT_BITLEN-1] == '1)
      requant_norm = r[OUT_BITLEN-1:0];
    else
      requant_norm = r[ACC_BITLEN-1] ? {1'b1, {(OUT_BITLEN-1){1'b0}}} : {1'b0, {(OUT_BITLEN-1){1'b1}}};
  endfunction

  function automatic logic [LANE_OUT_BITLEN-1:0] requant_lane(input logic signed [LANE_ACC_BITLEN-1:0] x,
                                                              input logic [4:0] shift);
    logic signed [LANE_ACC_BITLEN-1:0] rnd;
    logic signed [LANE_ACC_BITLEN-1:0] r;
    rnd = (shift == 5'd0) ? '0 : (LANE_ACC_BITLEN'(1) << (shift - 5'd1));
    r   = (x + rnd) >>> shift;
    if (r[LANE_ACC_BITLEN-1:LANE_OUT_BITLEN-1] == '0 || r[LANE_ACC_BITLEN-1:LANE_OUT_BITLEN-1] == '1)
      requant_lane = r[LANE_OUT_BITLEN-1:0];
    else
      requant_lane = r[LANE_ACC_BITLEN-1] ? {1'b1, {(LANE_OUT_BITLEN-1){1'b0}}}
                                          : {1'b0, {(LANE_OUT_BITLEN-1){1'b1}}};
  endfunction

endpackage

// File: rtl/vmx_result_collector_if.sv
// rtl/vmx_result_collector_if.sv - result stream interface of the vmx result collector
interface vmx_result_collector_if;
  import vmx_result_collector_pkg::*;

  logic [OUT_BITLEN-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/vmx_sync_fifo.sv
// rtl/vmx_sync_fifo.sv - single-clock FIFO; a read in the same cycle frees room for a write when full
module vmx_sync_fifo #(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (wr_ok && !rd_ok)
        count_q <= count_q + CNT_ONE;
      else if (rd_ok && !wr_ok)
        count_q <= count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/vmx_result_collector.sv
// rtl/vmx_result_collector.sv - accumulates PE partial sums, requantizes and streams results
module vmx_result_collector
  import vmx_result_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [CNT_BITLEN-1:0] cfg_acc_len,
  input  logic [CNT_BITLEN-1:0] cfg_out_len,
  input  logic [4:0]            cfg_shift,
  input  logic                  in_valid,
  input  logic [SUM_BITLEN-1:0] in_sum,
  input  logic                  in_simd,
  vmx_result_collector_if.master m_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow,
  output logic                  err_mode
);
  localparam logic [CNT_BITLEN-1:0] CNT_ONE = CNT_BITLEN'(1);

  state_t                state_q, state_d;
  logic [CNT_BITLEN-1:0] acc_len_q, out_len_q, beat_cnt_q, grp_cnt_q;
  logic [4:0]            shift_q;
  logic                  grp_simd_q;
  logic [ACC_BITLEN-1:0] acc_q, acc_d, acc_base;
  logic                  acc_vld_q, acc_last_q, acc_simd_q;
  logic [OUT_BITLEN-1:0] res_q;
  logic                  res_vld_q, res_last_q;
  logic                  err_ovf_q, err_mode_q;

  logic                  start_ok, accept, first_beat, beat_simd, grp_end;
  logic [LANE_ACC_BITLEN-1:0] up_ext, dw_ext;
  logic                  fifo_full, fifo_empty, fifo_rd;
  out_word_t             fifo_wdata, fifo_rdata;

  assign start_ok   = cfg_start && (state_q == ST_IDLE);
  // Once every group of the run has closed, further beats are ignored until the next start.
  assign accept     = in_valid && (state_q == ST_RUN) && (grp_cnt_q != out_len_q);
  assign first_beat = (beat_cnt_q == '0);
  assign beat_simd  = first_beat ? in_simd : grp_simd_q;
  assign grp_end    = accept && (beat_cnt_q == acc_len_q - CNT_ONE);

  always_comb begin
    acc_base = first_beat ? '0 : acc_q;
    up_ext   = {{(LANE_ACC_BITLEN-LANE_SUM_BITLEN){in_sum[SUM_BITLEN-1]}},
                in_sum[SUM_BITLEN-1:LANE_SUM_BITLEN]};
    dw_ext   = {{(LANE_ACC_BITLEN-LANE_SUM_BITLEN){in_sum[LANE_SUM_BITLEN-1]}},
                in_sum[LANE_SUM_BITLEN-1:0]};
    if (beat_simd)
      acc_d = {acc_base[ACC_BITLEN-1:LANE_ACC_BITLEN] + up_ext,
               acc_base[LANE_ACC_BITLEN-1:0] + dw_ext};
    else
      acc_d = acc_base + {{(ACC_BITLEN-SUM_BITLEN){in_sum[SUM_BITLEN-1]}}, in_sum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_len_q <= '0;
      out_len_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        acc_len_q <= (cfg_acc_len == '0) ? CNT_ONE : cfg_acc_len;
        out_len_q <= (cfg_out_len == '0) ? CNT_ONE : cfg_out_len;
        shift_q   <= cfg_shift;
      end
    end
  end

  // Three-stage path: acc_q holds the finished group sum, res_q the requantized word, then FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      grp_cnt_q  <= '0;
      grp_simd_q <= 1'b0;
      acc_q      <= '0;
      acc_vld_q  <= 1'b0;
      acc_last_q <= 1'b0;
      acc_simd_q <= 1'b0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      res_last_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_mode_q <= 1'b0;
    end else if (start_ok) begin
      beat_cnt_q <= '0;
      grp_cnt_q  <= '0;
      acc_vld_q  <= 1'b0;
      res_vld_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_mode_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_q      <= acc_d;
        beat_cnt_q <= grp_end ? '0 : beat_cnt_q + CNT_ONE;
        if (first_beat) grp_simd_q <= in_simd;
        if (!first_beat && (in_simd != grp_simd_q)) err_mode_q <= 1'b1;
      end
      if (grp_end) grp_cnt_q <= grp_cnt_q + CNT_ONE;
      acc_vld_q  <= grp_end;
      acc_last_q <= grp_end && (grp_cnt_q == out_len_q - CNT_ONE);
      acc_simd_q <= beat_simd;

      res_vld_q  <= acc_vld_q;
      res_last_q <= acc_last_q;
      if (acc_vld_q)
        res_q <= acc_simd_q ? {requant_lane(acc_q[ACC_BITLEN-1:LANE_ACC_BITLEN], shift_q),
                               requant_lane(acc_q[LANE_ACC_BITLEN-1:0], shift_q)}
                            : requant_norm(acc_q, shift_q);

      if (res_vld_q && fifo_full && !fifo_rd) err_ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:  if (cfg_start) state_d = ST_RUN;
      ST_RUN:   if (res_vld_q && res_last_q) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) begin
        state_d = ST_IDLE;
        done    = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign fifo_wdata = '{tlast: res_last_q, tdata: res_q};
  assign fifo_rd    = !fifo_empty && m_axis.tready;

  vmx_sync_fifo #(
    .DATA_W ($bits(out_word_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (res_vld_q),
    .wr_data (fifo_wdata),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty)
  );

  assign m_axis.tdata  = fifo_rdata.tdata;
  assign m_axis.tlast  = fifo_rdata.tlast;
  assign m_axis.tvalid = !fifo_empty;
  assign busy          = (state_q != ST_IDLE);
  assign err_overflow  = err_ovf_q;
  assign err_mode      = err_mode_q;
endmodule
